// File: rtl/pc_stack.sv
`default_nettype none
// ============================================================================
//  Module   : pc_stack
//  Purpose  : Program counter for the 4-bit microprocessor datapath.
//             - Increment, absolute load and PC-relative branch.
//             - Hardware call/return stack with DEPTH entries.
//             - Full/empty status and a sticky overflow/underflow error flag.
//             - Tri-state bus copy of the PC plus an always-driven copy.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    AW     PC / address width in bits
//    DEPTH  return-stack entries (>= 2, any value)
//    OW     signed relative-branch offset width (<= AW)
//  Ports
//    clk        in   1   rising-edge clock
//    clr        in   1   synchronous active-low reset
//    pc_inc     in   1   PC <= PC + 1
//    load_pc    in   1   PC <= pc_input
//    rel_br     in   1   PC <= PC + sext(br_off)
//    br_off     in   OW  signed branch offset
//    call       in   1   push PC + 1, PC <= pc_input
//    ret        in   1   PC <= top of stack, pop
//    pc_input   in   AW  jump / call target
//    pc_oen     in   1   bus output enable
//    pc_out     out  AW  PC when pc_oen = 1, otherwise high-Z
//    pc_q       out  AW  PC, always driven
//    stk_empty  out  1   stack holds no entries
//    stk_full   out  1   stack holds DEPTH entries
//    stk_err    out  1   sticky overflow / underflow flag
// ============================================================================
module pc_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 4,
  parameter int OW    = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          pc_inc,
  input  logic          load_pc,
  input  logic          rel_br,
  input  logic [OW-1:0] br_off,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] pc_input,
  input  logic          pc_oen,
  output logic [AW-1:0] pc_out,
  output logic [AW-1:0] pc_q,
  output logic          stk_empty,
  output logic          stk_full,
  output logic          stk_err
);

  // The stack pointer must be able to represent 0..DEPTH inclusive.
  localparam int             SPW       = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] C_SP_ZERO = '0;
  localparam logic [SPW-1:0] C_SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] C_SP_FULL = SPW'(DEPTH);
  localparam logic [AW-1:0]  C_PC_ONE  = AW'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [AW-1:0]  pc_cur_q, pc_cur_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic [AW-1:0]  stack_q [DEPTH];

  // --------------------------------------------------------------------------
  // Datapath helpers
  // --------------------------------------------------------------------------
  logic [AW-1:0] br_sext;
  logic [AW-1:0] pc_plus1;
  logic [AW-1:0] pc_branch;
  logic [AW-1:0] top_of_stack;
  logic          sp_is_empty;
  logic          sp_is_full;
  logic          push_en;

  // Sign-extend the branch offset up to the address width; when the offset
  // already spans the full width it is used as is.
  generate
    if (OW < AW) begin : g_sext_ext
      assign br_sext = {{(AW-OW){br_off[OW-1]}}, br_off};
    end else begin : g_sext_full
      assign br_sext = br_off[AW-1:0];
    end
  endgenerate

  // Both additions wrap naturally modulo 2^AW.
  assign pc_plus1  = pc_cur_q + C_PC_ONE;
  assign pc_branch = pc_cur_q + br_sext;

  assign sp_is_empty = (sp_q == C_SP_ZERO);
  assign sp_is_full  = (sp_q == C_SP_FULL);

  // Top-of-stack read: entry sp-1. Decoded with a compare per entry so that a
  // non-power-of-two DEPTH never produces an out-of-range array index.
  always_comb begin
    top_of_stack = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SPW'(i + 1)) begin
        top_of_stack = stack_q[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Command decode, highest priority first: ret, call, load, rel_br, inc.
  // Lower-priority requests in the same cycle are simply dropped.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_cur_d = pc_cur_q;
    sp_d     = sp_q;
    err_d    = err_q;
    push_en  = 1'b0;

    if (ret) begin
      if (!sp_is_empty) begin
        pc_cur_d = top_of_stack;
        sp_d     = sp_q - C_SP_ONE;
      end else begin
        // Underflow: nothing moves, only the error is recorded.
        err_d = 1'b1;
      end
    end else if (call) begin
      if (!sp_is_full) begin
        push_en  = 1'b1;
        pc_cur_d = pc_input;
        sp_d     = sp_q + C_SP_ONE;
      end else begin
        // Overflow: the whole call is suppressed, including the jump.
        err_d = 1'b1;
      end
    end else if (load_pc) begin
      pc_cur_d = pc_input;
    end else if (rel_br) begin
      pc_cur_d = pc_branch;
    end else if (pc_inc) begin
      pc_cur_d = pc_plus1;
    end
  end

  // --------------------------------------------------------------------------
  // Control registers with synchronous active-low reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr) begin
      pc_cur_q <= '0;
      sp_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      pc_cur_q <= pc_cur_d;
      sp_q     <= sp_d;
      err_q    <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stack storage. Contents are never reset; a push is blocked while reset
  // is asserted so a call coinciding with reset leaves the RAM untouched.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clr && push_en && (sp_q == SPW'(i))) begin
        stack_q[i] <= pc_plus1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pc_q      = pc_cur_q;
  assign pc_out    = pc_oen ? pc_cur_q : {AW{1'bz}};
  assign stk_empty = sp_is_empty;
  assign stk_full  = sp_is_full;
  assign stk_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_stack
//  Purpose  : Self-checking bench for pc_stack (AW=8, DEPTH=4, OW=4).
//             A reference model predicts each cycle's outputs; predictions
//             are queued when a command is driven and compared after the edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_stack;

  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int OW    = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          pc_inc;
  logic          load_pc;
  logic          rel_br;
  logic [OW-1:0] br_off;
  logic          call;
  logic          ret;
  logic [AW-1:0] pc_input;
  logic          pc_oen;
  logic [AW-1:0] pc_out;
  logic [AW-1:0] pc_q;
  logic          stk_empty;
  logic          stk_full;
  logic          stk_err;

  always #5 clk = ~clk;

  pc_stack #(.AW(AW), .DEPTH(DEPTH), .OW(OW)) dut (
    .clk      (clk),
    .clr      (clr),
    .pc_inc   (pc_inc),
    .load_pc  (load_pc),
    .rel_br   (rel_br),
    .br_off   (br_off),
    .call     (call),
    .ret      (ret),
    .pc_input (pc_input),
    .pc_oen   (pc_oen),
    .pc_out   (pc_out),
    .pc_q     (pc_q),
    .stk_empty(stk_empty),
    .stk_full (stk_full),
    .stk_err  (stk_err)
  );

  // Reference model state
  logic [AW-1:0] m_pc;
  int            m_sp;
  logic [AW-1:0] m_stk [DEPTH];
  logic          m_err;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          empty;
    logic          full;
    logic          err;
    logic          oen;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_step();
    if (!clr) begin
      m_pc  = '0;
      m_sp  = 0;
      m_err = 1'b0;
    end else if (ret) begin
      if (m_sp > 0) begin
        m_sp = m_sp - 1;
        m_pc = m_stk[m_sp];
      end else begin
        m_err = 1'b1;
      end
    end else if (call) begin
      if (m_sp < DEPTH) begin
        m_stk[m_sp] = m_pc + 8'd1;
        m_sp = m_sp + 1;
        m_pc = pc_input;
      end else begin
        m_err = 1'b1;
      end
    end else if (load_pc) begin
      m_pc = pc_input;
    end else if (rel_br) begin
      m_pc = m_pc + {{(AW-OW){br_off[OW-1]}}, br_off};
    end else if (pc_inc) begin
      m_pc = m_pc + 8'd1;
    end
  endtask

  // Drive one cycle of commands, predict, wait for the edge, compare.
  task automatic cycle(input logic c_ret, input logic c_call, input logic c_load,
                       input logic c_rel, input logic c_inc,
                       input logic [AW-1:0] tgt, input logic [OW-1:0] off,
                       input logic oen);
    exp_t e;
    ret      = c_ret;
    call     = c_call;
    load_pc  = c_load;
    rel_br   = c_rel;
    pc_inc   = c_inc;
    pc_input = tgt;
    br_off   = off;
    pc_oen   = oen;
    model_step();
    e.pc    = m_pc;
    e.empty = (m_sp == 0);
    e.full  = (m_sp == DEPTH);
    e.err   = m_err;
    e.oen   = oen;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      check("pc_q", pc_q, e.pc);
      check("stk_empty", {7'd0, stk_empty}, {7'd0, e.empty});
      check("stk_full", {7'd0, stk_full}, {7'd0, e.full});
      check("stk_err", {7'd0, stk_err}, {7'd0, e.err});
      check("pc_out", pc_out, e.oen ? e.pc : {AW{1'bz}});
    end
  endtask

  initial begin
    clr = 1'b0; pc_inc = 0; load_pc = 0; rel_br = 0; call = 0; ret = 0;
    br_off = '0; pc_input = '0; pc_oen = 1'b0;
    m_pc = 'x; m_sp = 0; m_err = 1'b0;

    // Reset: bus released, then bus driving 0
    cycle(0, 0, 0, 0, 0, 8'h00, 4'h0, 1'b0);
    check("reset_pc", pc_q, 8'h00);
    cycle(0, 0, 0, 0, 0, 8'h00, 4'h0, 1'b1);
    check("reset_bus", pc_out, 8'h00);
    clr = 1'b1;

    // Increment wrap over all 256 values
    for (int i = 0; i < 256; i++) begin
      cycle(0, 0, 0, 0, 1, 8'h00, 4'h0, 1'(i & 1));
    end
    check("inc_wrap", pc_q, 8'h00);

    // Load and relative branch
    cycle(0, 0, 1, 0, 0, 8'h40, 4'h0, 1'b1);
    cycle(0, 0, 0, 1, 0, 8'h00, 4'b1100, 1'b1);
    check("rel_minus4", pc_q, 8'h3C);
    cycle(0, 0, 0, 1, 0, 8'h00, 4'b0111, 1'b0);
    check("rel_plus7", pc_q, 8'h43);
    cycle(0, 0, 1, 0, 0, 8'h02, 4'h0, 1'b0);
    cycle(0, 0, 0, 1, 0, 8'h00, 4'b1100, 1'b0);
    check("rel_wrap", pc_q, 8'hFE);

    // Nested call / return
    cycle(0, 0, 1, 0, 0, 8'h10, 4'h0, 1'b0);
    cycle(0, 1, 0, 0, 0, 8'h80, 4'h0, 1'b0);
    check("call1", pc_q, 8'h80);
    cycle(0, 1, 0, 0, 0, 8'hA0, 4'h0, 1'b0);
    check("call2", pc_q, 8'hA0);
    cycle(1, 0, 0, 0, 0, 8'h00, 4'h0, 1'b0);
    check("ret1", pc_q, 8'h81);
    cycle(1, 0, 0, 0, 0, 8'h00, 4'h0, 1'b0);
    check("ret2", pc_q, 8'h11);
    check("nest_empty", {7'd0, stk_empty}, 8'h01);
    check("nest_err", {7'd0, stk_err}, 8'h00);

    // Overflow: four legal calls, fifth suppressed
    cycle(0, 1, 0, 0, 0, 8'h20, 4'h0, 1'b0);
    cycle(0, 1, 0, 0, 0, 8'h30, 4'h0, 1'b0);
    cycle(0, 1, 0, 0, 0, 8'h40, 4'h0, 1'b0);
    cycle(0, 1, 0, 0, 0, 8'h50, 4'h0, 1'b0);
    check("ovf_full", {7'd0, stk_full}, 8'h01);
    cycle(0, 1, 0, 0, 0, 8'h99, 4'h0, 1'b0);
    check("ovf_pc", pc_q, 8'h50);
    check("ovf_err", {7'd0, stk_err}, 8'h01);
    cycle(1, 0, 0, 0, 0, 8'h00, 4'h0, 1'b0);
    check("lifo1", pc_q, 8'h41);
    cycle(1, 0, 0, 0, 0, 8'h00, 4'h0, 1'b0);
    check("lifo2", pc_q, 8'h31);
    cycle(1, 0, 0, 0, 0, 8'h00, 4'h0, 1'b0);
    check("lifo3", pc_q, 8'h21);
    cycle(1, 0, 0, 0, 0, 8'h00, 4'h0, 1'b0);
    check("lifo4", pc_q, 8'h12);
    check("err_sticky", {7'd0, stk_err}, 8'h01);

    // Underflow
    cycle(1, 0, 0, 0, 0, 8'h00, 4'h0, 1'b0);
    check("udf_pc", pc_q, 8'h12);

    // Priority: ret wins over call/load/inc with one entry stacked
    cycle(0, 1, 0, 0, 0, 8'h60, 4'h0, 1'b0);
    cycle(1, 1, 1, 0, 1, 8'h77, 4'h0, 1'b0);
    check("prio_ret", pc_q, 8'h13);
    check("prio_empty", {7'd0, stk_empty}, 8'h01);
    // load beats inc
    cycle(0, 0, 1, 0, 1, 8'h33, 4'h0, 1'b0);
    check("prio_load", pc_q, 8'h33);

    // Reset during a call with sp=3, err=1, PC=0x55
    cycle(0, 1, 0, 0, 0, 8'h01, 4'h0, 1'b0);
    cycle(0, 1, 0, 0, 0, 8'h02, 4'h0, 1'b0);
    cycle(0, 1, 0, 0, 0, 8'h03, 4'h0, 1'b0);
    cycle(0, 0, 1, 0, 0, 8'h55, 4'h0, 1'b0);
    clr = 1'b0;
    cycle(0, 1, 0, 0, 0, 8'h88, 4'h0, 1'b1);
    clr = 1'b1;
    check("rst_mid_pc", pc_q, 8'h00);
    check("rst_mid_err", {7'd0, stk_err}, 8'h00);
    // Stack must really be empty: ret underflows and PC stays 0
    cycle(1, 0, 0, 0, 0, 8'h00, 4'h0, 1'b0);
    check("rst_no_push", pc_q, 8'h00);

    // Back-to-back call then ret
    cycle(0, 1, 0, 0, 0, 8'h90, 4'h0, 1'b1);
    cycle(1, 0, 0, 0, 0, 8'h00, 4'h0, 1'b1);
    check("call_ret_b2b", pc_q, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter for the 4-bit microprocessor datapath, successor to the 8-bit increment/load PC. It adds configurable address width, PC-relative branching, and a hardware call/return stack of configurable depth with full/empty status and a sticky error flag. It keeps the tri-state bus output and adds an always-driven copy of the PC for the sequencer and debug logic.

## Interface
- `AW`, default 8: PC / address width in bits.
- `DEPTH`, default 4: return-stack entries. Must be ≥ 2; a power of 2 is not required.
- `OW`, default 4: width of the signed relative-branch offset, two's complement. Must be ≤ `AW`.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `clr`  in  1: reset, synchronous, active-low.
- `pc_inc`  in  1: increment the PC.
- `load_pc`  in  1: absolute jump; PC <= `pc_input`.
- `rel_br`  in  1: relative branch; PC <= PC + sext(`br_off`).
- `br_off`  in  `OW`: signed branch offset.
- `call`  in  1: push PC+1, then PC <= `pc_input`.
- `ret`  in  1: PC <= top of stack, then pop.
- `pc_input`  in  `AW`: jump/call target.
- `pc_oen`  in  1: bus output enable.
- `pc_out`  out  `AW`: PC on the shared bus when `pc_oen`=1, otherwise high-Z.
- `pc_q`  out  `AW`: PC, always driven.
- `stk_empty`  out  1: stack holds 0 entries.
- `stk_full`  out  1: stack holds `DEPTH` entries.
- `stk_err`  out  1: sticky overflow/underflow flag.

## Operation
State:
- PC register, `AW` bits.
- Stack pointer `sp`, range 0..`DEPTH`.
- Stack RAM of `DEPTH`×`AW` registers.
- `stk_err` register.

Reset: while `clr`=0 at a rising edge, set PC=0, `sp`=0, `stk_err`=0. Stack RAM contents are not reset and are don't-care. Resetting overrides any command in the same cycle, including mid-call/return sequences.

Command priority, one action per cycle, highest first:
1. `ret`
   - If `sp`>0: PC <= stack[`sp`-1]; `sp` <= `sp`-1.
   - If `sp`=0 (underflow): PC holds, `sp` holds, `stk_err` <= 1.
2. `call`
   - If `sp`<`DEPTH`: stack[`sp`] <= PC+1 (mod 2^`AW`); `sp` <= `sp`+1; PC <= `pc_input`.
   - If `sp`=`DEPTH` (overflow): the whole call is suppressed. PC holds, stack is unchanged, `stk_err` <= 1.
3. `load_pc`: PC <= `pc_input`.
4. `rel_br`: PC <= PC + sign-extended `br_off`, modulo 2^`AW`. The offset is relative to the current PC, not PC+1.
5. `pc_inc`: PC <= PC+1, modulo 2^`AW`; wraps from all-ones to 0.
6. No command asserted: PC holds.

Rules:
- Lower-priority requests in the same cycle are dropped, not queued. For example, `ret`+`call` executes only the `ret`.
- `stk_err` is cleared only by reset. Later legal operations do not clear it.

Outputs:
- `pc_q` equals the PC register.
- `pc_out` = `pc_oen` ? PC : all-Z. It is combinational from `pc_oen` and the register.
- `stk_empty` = (`sp`==0) and `stk_full` = (`sp`==`DEPTH`). Both decode from the registered `sp`.

## Timing
- Every command takes effect at the first rising edge where it is sampled. `pc_q`, `pc_out`, `stk_empty`, `stk_full` and `stk_err` show the result after that edge: 1-cycle latency, no multi-cycle operations.
- Back-to-back commands are legal every cycle, including `call` followed immediately by `ret`, which returns to the caller's PC+1 on the second edge.
- `pc_oen` has no clock dependency: the bus drives and releases combinationally.
- Output values in reset: `pc_q`=0, `stk_empty`=1, `stk_full`=0, `stk_err`=0, `pc_out` = Z if `pc_oen`=0 and 0 if `pc_oen`=1.
- All inputs are synchronous to `clk`. No handshake; the controller guarantees one intended command per cycle and priority resolves any overlap.

## Test plan
- **Reset/increment wrap:** `clr`=0 then release; pulse `pc_inc` 256 times with `AW`=8. Required: `pc_q` counts 0,1,…,255,0. With `pc_oen`=0, `pc_out` is Z; with `pc_oen`=1, `pc_out` = `pc_q`.
- **Load and relative branch:** `load_pc` with `pc_input`=0x40. Then `rel_br` with `br_off`=4'b1100 (−4) gives 0x3C. Then `rel_br` with `br_off`=4'b0111 (+7) gives 0x43. From PC=0x02, `br_off`=−4 wraps to 0xFE.
- **Nested call/return:** from PC=0x10, `call` 0x80, then `call` 0xA0, then `ret`, then `ret`. Required PC sequence: 0x80, 0xA0, 0x81, 0x11. `stk_empty` reads 0,0,0,1 after each edge. `stk_err` stays 0.
- **Overflow:** with `DEPTH`=4, perform 4 legal calls; `stk_full`=1. A 5th `call` leaves PC and `sp` unchanged and sets `stk_err`=1. Four `ret`s then return the four pushed addresses in LIFO order. `stk_err` stays 1.
- **Underflow and priority:**
  - `ret` on an empty stack: PC holds and `stk_err`=1.
  - With `sp`=1, assert `ret`, `call`, `load_pc` and `pc_inc` together. Only the `ret` executes: PC = the popped value and `sp`=0.
  - `load_pc` together with `pc_inc`: PC = `pc_input`.
- **Reset mid-operation:** with `sp`=3, `stk_err`=1, PC=0x55, assert `clr`=0 in the same cycle as `call`. Required after the edge: PC=0, `stk_empty`=1, `stk_err`=0, and no push occurred.
